// File: rtl/bus_xfer_sequencer_if.sv
// Request and strobe bundle between the control unit, the transfer sequencer
// and the bus mux / register load enables.
interface bus_xfer_sequencer_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned NSRC  = 24
);
  localparam int unsigned CNTW = $clog2(DEPTH) + 1;

  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_src;
  logic [4:0]      req_dst;
  logic            mem_ready;
  logic [NSRC-1:0] src_out;
  logic [NSRC-1:0] dst_in;
  logic            xfer_done;
  logic            err_invalid;
  logic            busy;
  logic [CNTW-1:0] count;

  // Control-unit / memory side: issues requests, reports MDR readiness.
  modport master (
    output req_valid, req_src, req_dst, mem_ready,
    input  req_ready, src_out, dst_in, xfer_done, err_invalid, busy, count
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_src, req_dst, mem_ready,
    output req_ready, src_out, dst_in, xfer_done, err_invalid, busy, count
  );
endinterface

// File: rtl/bus_xfer_sequencer.sv
// Queues (source, destination) transfer requests and turns each into one-hot
// bus-source and register-load strobes, stalling MDR reads until memory is ready.
module bus_xfer_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned NSRC     = 24,
  parameter int unsigned MDR_CODE = 21
) (
  input  logic                 clk,
  input  logic                 clr,
  bus_xfer_sequencer_if.slave  bus
);
  localparam int unsigned CW   = 5;
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;

  typedef struct packed {
    logic [CW-1:0] src;
    logic [CW-1:0] dst;
  } xfer_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRIVE    = 2'd1,
    WAIT_MEM = 2'd2
  } state_t;

  state_t          state;
  xfer_t           mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nxt;
  logic [CW-1:0]   pend_dst;
  logic            push;
  logic            pop;
  xfer_t           head;
  logic            head_invalid;
  logic            head_stall;

  function automatic logic [NSRC-1:0] onehot(input logic [CW-1:0] code);
    logic [NSRC-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      v[i] = (code == CW'(i));
    end
    return v;
  endfunction

  // Handshake, head decode and next occupancy.
  always_comb begin
    push         = bus.req_valid && bus.req_ready;
    pop          = (state != WAIT_MEM) && (cnt != '0);
    head         = mem[rd_ptr];
    head_invalid = (32'(head.src) >= NSRC) || (32'(head.dst) >= NSRC);
    head_stall   = (head.src == CW'(MDR_CODE)) && !bus.mem_ready;
    cnt_nxt      = cnt;
    if (push && !pop) begin
      cnt_nxt = cnt + CNTW'(1);
    end else if (!push && pop) begin
      cnt_nxt = cnt - CNTW'(1);
    end
  end

  assign bus.count = cnt;

  // Circular FIFO pointers and occupancy; ready is registered from next occupancy.
  always_ff @(posedge clk) begin
    if (!clr) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      cnt           <= '0;
      bus.req_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt           <= cnt_nxt;
      bus.req_ready <= (cnt_nxt != CNTW'(DEPTH));
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (clr && push) begin
      mem[wr_ptr] <= '{src: bus.req_src, dst: bus.req_dst};
    end
  end

  // Transfer FSM with registered strobes.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state           <= IDLE;
      pend_dst        <= '0;
      bus.src_out     <= '0;
      bus.dst_in      <= '0;
      bus.xfer_done   <= 1'b0;
      bus.err_invalid <= 1'b0;
      bus.busy        <= 1'b0;
    end else begin
      bus.src_out     <= '0;
      bus.dst_in      <= '0;
      bus.xfer_done   <= 1'b0;
      bus.err_invalid <= 1'b0;
      // The engine stays non-idle next cycle whenever it pops or is parked on memory.
      bus.busy        <= pop || (state == WAIT_MEM) || (cnt_nxt != '0);

      case (state)
        IDLE, DRIVE: begin
          if (pop) begin
            if (head_invalid) begin
              state           <= DRIVE;
              bus.err_invalid <= 1'b1;
            end else if (head_stall) begin
              state       <= WAIT_MEM;
              pend_dst    <= head.dst;
              bus.src_out <= onehot(head.src);
            end else begin
              state         <= DRIVE;
              bus.src_out   <= onehot(head.src);
              bus.dst_in    <= onehot(head.dst);
              bus.xfer_done <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end

        WAIT_MEM: begin
          bus.src_out <= onehot(CW'(MDR_CODE));
          if (bus.mem_ready) begin
            state         <= DRIVE;
            bus.dst_in    <= onehot(pend_dst);
            bus.xfer_done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed and random stimulus for bus_xfer_sequencer, checked every cycle
// against a queue-based transfer model plus literal expectations.
module tb_bus_xfer_sequencer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NSRC  = 24;
  localparam int unsigned MDR   = 21;

  logic clk = 1'b0;
  logic clr;

  always #5 clk = ~clk;

  bus_xfer_sequencer_if #(.DEPTH(DEPTH), .NSRC(NSRC)) bus ();

  bus_xfer_sequencer #(.DEPTH(DEPTH), .NSRC(NSRC), .MDR_CODE(MDR)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct { int src; int dst; } req_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending requests, and the destination of a read parked on memory.
  req_t            q[$];
  int              wait_dst = -1;
  logic [NSRC-1:0] m_src;
  logic [NSRC-1:0] m_dst;
  logic            m_done;
  logic            m_err;
  logic            m_busy;

  function automatic logic [NSRC-1:0] oh(input int c);
    logic [NSRC-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Applies one rising edge's worth of spec rules to the model, using the driven inputs.
  task automatic model_edge();
    bit   engaged;
    bit   can_push;
    req_t e;
    m_src = '0; m_dst = '0; m_done = 1'b0; m_err = 1'b0;
    if (!clr) begin
      q.delete();
      wait_dst = -1;
      m_busy   = 1'b0;
      return;
    end
    engaged  = 1'b0;
    can_push = bus.req_valid && (q.size() < DEPTH);
    if (wait_dst >= 0) begin
      engaged = 1'b1;
      m_src   = oh(MDR);
      if (bus.mem_ready) begin
        m_dst    = oh(wait_dst);
        m_done   = 1'b1;
        wait_dst = -1;
      end
    end else if (q.size() > 0) begin
      e       = q.pop_front();
      engaged = 1'b1;
      if (e.src >= NSRC || e.dst >= NSRC) begin
        m_err = 1'b1;
      end else if (e.src == MDR && !bus.mem_ready) begin
        m_src    = oh(MDR);
        wait_dst = e.dst;
      end else begin
        m_src  = oh(e.src);
        m_dst  = oh(e.dst);
        m_done = 1'b1;
      end
    end
    if (can_push) q.push_back('{int'(bus.req_src), int'(bus.req_dst)});
    m_busy = engaged || (q.size() != 0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".src_out"}, 64'(bus.src_out), 64'(m_src));
    chk({tag, ".dst_in"}, 64'(bus.dst_in), 64'(m_dst));
    chk({tag, ".xfer_done"}, 64'(bus.xfer_done), 64'(m_done));
    chk({tag, ".err_invalid"}, 64'(bus.err_invalid), 64'(m_err));
    chk({tag, ".busy"}, 64'(bus.busy), 64'(m_busy));
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(q.size() < DEPTH));
    chk({tag, ".count"}, 64'(bus.count), 64'(q.size()));
    chk({tag, ".src_onehot"}, 64'($countones(bus.src_out) <= 1), 64'(1));
    chk({tag, ".dst_onehot"}, 64'($countones(bus.dst_in) <= 1), 64'(1));
    chk({tag, ".dst_implies_src"}, 64'((bus.dst_in == '0) || (bus.src_out != '0)), 64'(1));
    chk({tag, ".done_eq_dst"}, 64'(bus.xfer_done), 64'(bus.dst_in != '0));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input int s, input int d);
    bus.req_valid = v;
    bus.req_src   = 5'(s);
    bus.req_dst   = 5'(d);
  endtask

  initial begin
    clr = 1'b0;
    drive(1'b0, 0, 0);
    bus.mem_ready = 1'b0;

    // Reset
    tick("rst0");
    tick("rst1");
    chk("rst.count", 64'(bus.count), 64'(0));
    chk("rst.ready", 64'(bus.req_ready), 64'(1));
    chk("rst.busy", 64'(bus.busy), 64'(0));
    chk("rst.src", 64'(bus.src_out), 64'(0));
    clr = 1'b1;
    tick("idle");

    // Single transfer 3 -> 7
    drive(1'b1, 3, 7);
    tick("t1.push");
    drive(1'b0, 0, 0);
    chk("t1.count", 64'(bus.count), 64'(1));
    tick("t1.xfer");
    chk("t1.src", 64'(bus.src_out), 64'h000008);
    chk("t1.dst", 64'(bus.dst_in), 64'h000080);
    chk("t1.done", 64'(bus.xfer_done), 64'(1));
    tick("t1.after");
    chk("t1.src0", 64'(bus.src_out), 64'(0));
    chk("t1.busy0", 64'(bus.busy), 64'(0));

    // Fill behind a stalled MDR read, reject a push while full, then drain back-to-back
    drive(1'b1, 21, 9);  tick("t2.p0");
    drive(1'b1, 0, 1);   tick("t2.p1");
    drive(1'b1, 1, 2);   tick("t2.p2");
    drive(1'b1, 2, 3);   tick("t2.p3");
    chk("t2.ready3", 64'(bus.req_ready), 64'(1));
    drive(1'b1, 20, 21); tick("t2.p4");
    chk("t2.full_count", 64'(bus.count), 64'(4));
    chk("t2.full_ready", 64'(bus.req_ready), 64'(0));
    drive(1'b1, 6, 6);   tick("t2.p5");
    chk("t2.rej_count", 64'(bus.count), 64'(4));
    drive(1'b0, 0, 0);
    bus.mem_ready = 1'b1;
    tick("t2.d0");
    chk("t2.d0.src", 64'(bus.src_out), 64'h200000);
    chk("t2.d0.dst", 64'(bus.dst_in), 64'h000200);
    tick("t2.d1");
    chk("t2.d1.dst", 64'(bus.dst_in), 64'h000002);
    tick("t2.d2");
    chk("t2.d2.dst", 64'(bus.dst_in), 64'h000004);
    tick("t2.d3");
    chk("t2.d3.dst", 64'(bus.dst_in), 64'h000008);
    tick("t2.d4");
    chk("t2.d4.src", 64'(bus.src_out), 64'h100000);
    chk("t2.d4.dst", 64'(bus.dst_in), 64'h200000);
    tick("t2.d5");
    chk("t2.d5.src", 64'(bus.src_out), 64'(0));

    // MDR read held three cycles by mem_ready
    bus.mem_ready = 1'b0;
    drive(1'b1, 21, 5); tick("t3.push");
    drive(1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("t3.wait");
      chk("t3.wait.src", 64'(bus.src_out), 64'h200000);
      chk("t3.wait.dst", 64'(bus.dst_in), 64'(0));
    end
    bus.mem_ready = 1'b1;
    tick("t3.go");
    chk("t3.go.src", 64'(bus.src_out), 64'h200000);
    chk("t3.go.dst", 64'(bus.dst_in), 64'h000020);
    chk("t3.go.done", 64'(bus.xfer_done), 64'(1));
    tick("t3.end");

    // Invalid entry followed by src == dst
    drive(1'b1, 25, 2); tick("t4.p0");
    drive(1'b1, 4, 4);  tick("t4.err");
    drive(1'b0, 0, 0);
    chk("t4.err.flag", 64'(bus.err_invalid), 64'(1));
    chk("t4.err.src", 64'(bus.src_out), 64'(0));
    tick("t4.same");
    chk("t4.same.src", 64'(bus.src_out), 64'h000010);
    chk("t4.same.dst", 64'(bus.dst_in), 64'h000010);
    chk("t4.same.done", 64'(bus.xfer_done), 64'(1));
    tick("t4.end");

    // Reset while parked on memory discards everything
    bus.mem_ready = 1'b0;
    drive(1'b1, 21, 5); tick("t5.p0");
    drive(1'b1, 1, 2);  tick("t5.p1");
    drive(1'b1, 3, 4);  tick("t5.p2");
    drive(1'b1, 7, 8);  tick("t5.p3");
    drive(1'b0, 0, 0);  tick("t5.hold");
    clr = 1'b0;
    tick("t5.rst");
    chk("t5.count", 64'(bus.count), 64'(0));
    chk("t5.ready", 64'(bus.req_ready), 64'(1));
    chk("t5.busy", 64'(bus.busy), 64'(0));
    chk("t5.src", 64'(bus.src_out), 64'(0));
    clr = 1'b1;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("t5.post");
      chk("t5.post.src", 64'(bus.src_out), 64'(0));
    end

    // Steady push+pop at count = DEPTH-1, wrapping the pointers
    bus.mem_ready = 1'b0;
    drive(1'b1, 21, 0); tick("t6.p0");
    drive(1'b1, 8, 9);  tick("t6.p1");
    drive(1'b1, 9, 10); tick("t6.p2");
    drive(1'b1, 10, 11); tick("t6.p3");
    drive(1'b0, 0, 0);
    bus.mem_ready = 1'b1;
    tick("t6.release");
    chk("t6.release.count", 64'(bus.count), 64'(3));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 11 + i, 12 + i);
      tick("t6.steady");
      chk("t6.steady.count", 64'(bus.count), 64'(3));
      chk("t6.steady.src", 64'(bus.src_out), 64'(oh(8 + i)));
    end
    drive(1'b0, 0, 0);
    for (int i = 0; i < 5; i++) tick("t6.drain");
    chk("t6.drained", 64'(bus.busy), 64'(0));

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int s;
      s = ($urandom_range(0, 7) == 0) ? int'(MDR) : int'($urandom_range(0, 27));
      drive(($urandom_range(0, 9) < 6), s, int'($urandom_range(0, 27)));
      bus.mem_ready = ($urandom_range(0, 1) == 1);
      clr = ($urandom_range(0, 79) != 0);
      tick("rnd");
    end
    clr = 1'b1;
    drive(1'b0, 0, 0);
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick("rnd.drain");
    chk("rnd.idle", 64'(bus.busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
